uart_mmio_ctrl: RTL and testbench
=================================

// Module: uart_mmio_ctrl
// PURPOSE
//  Memory-mapped 8N1 UART: parametrised TX/RX FIFOs, runtime baud divisor, sticky error flags.
//  Sits on the CPU data-bus decode path in place of the fixed-baud UART.
//  Provides internal serializer/deserializer FSMs and edge-qualified bus side effects.
// PARAMETERS
//  CLK_FREQ    109000000     system clock, Hz
//  BAUD        9600          reset baud; DIV_RST = CLK_FREQ/BAUD
//  FIFO_DEPTH  16            entries per FIFO, power of 2, 2..128
//  BASE_ADDR   32'hBFD003F0  IER=+0x0, CTRL=+0x4, DATA=+0x8, STATUS=+0xC
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous active-high reset
//  mem_addr_i  in   32  bus address, full compare
//  mem_data_i  in   32  bus write data
//  mem_oe_n    in   1   read strobe, active low
//  mem_we_n    in   1   write strobe, active low; takes priority over oe_n
//  serial_o    out  32  read data, combinational; 0 when not addressed
//  txd         out  1   serial out, idle high
//  rxd         in   1   serial in, asynchronous
//  irq         out  1   interrupt, level, registered
// BEHAVIOUR
//  Reset: all state async-cleared; txd=1, irq=0, FIFOs empty, flags 0, CTRL=DIV_RST, IER=0.
//  Write: acts once, on first cycle of we_n low (we_n 1->0 edge, registered prev); data sampled then.
//   A held strobe never repeats the write.
//  Read: serial_o valid for whole oe_n-low window.
//   Side effects (DATA pop, STATUS flag clear) at the first cycle oe_n is high after an access.
//   Access address is latched at the oe_n 1->0 edge.
//  DATA wr: push mem_data_i[7:0] to TX FIFO; if full, drop and set TX_OVF.
//  DATA rd: {24'd0, RX head}; empty FIFO reads 0, no pop.
//  STATUS rd: [0] TX FIFO not full; [1] RX not empty; [2] TX idle (FIFO empty and FSM IDLE).
//   [3] RX_OVR, [4] FRM_ERR, [5] TX_OVF are sticky, cleared by STATUS read.
//   [15:8] RX count; [23:16] TX count; others 0. Flag set beats clear in the same cycle.
//  CTRL: [15:0] divisor, clocks per bit; writes <4 clamp to 4.
//   Latched at each frame start, so mid-frame writes affect the next frame.
//  FIFOs: count width log2(DEPTH)+1, pointers wrap mod DEPTH.
//   Push+pop same cycle: both occur when neither blocks. Full+pop+push: both occur, count unchanged.
//   Empty+push+pop: pop ignored.
//  TX FSM IDLE->START->DATA(8, LSB first)->STOP->IDLE; each state = divisor clocks.
//   Pops a FIFO byte in IDLE when non-empty; pop-to-txd-low latency 1 clk.
//   Back-to-back frames leave no idle gap.
//  RX: rxd passes a 2-flop sync. FSM IDLE->START->DATA->STOP.
//   Falling edge: wait div/2, resample; high = glitch, back to IDLE.
//   Data sampled every div clocks. Stop sampled low: discard byte, set FRM_ERR.
//   Valid byte pushed at stop sample; RX full: drop, set RX_OVR.
//  Reset mid-frame aborts both FSMs immediately; no partial byte stored.
// CONFIGURATION
//  UART_IRQ_EN defined: IER [0] RX-not-empty, [1] TX-FIFO-empty, [2] any sticky error.
//   irq = OR of enabled conditions, registered, 1 clk latency.
//  Undefined: IER reads 0, writes ignored, irq tied 0, no IER storage.
// TESTING
//  CTRL=16, DATA=0x55 -> txd 0 for 16 clk, then 1,0,1,0,1,0,1,0 at 16 clk each, stop 1; STATUS[2]=1 after 160 clk.
//  CTRL=1000, 18 back-to-back DATA writes -> 17 accepted (1 in shifter+16 queued), 18th dropped, STATUS[5]=1, [0]=0.
//  rxd frame 0xA3 at div 16 -> STATUS[1]=1, DATA rd=0x000000A3; after oe_n rises STATUS[1]=0, [15:8]=0.
//  17 rx frames unread -> count 16, STATUS[3]=1; second STATUS rd shows [3]=0; 3-clk low glitch on rxd -> nothing stored.
//  Frame with stop bit 0 -> no push, STATUS[4]=1; IRQ_EN build with IER=4 -> irq=1 1 clk later.
//  we_n low 4 clk on DATA -> exactly 1 push; rst pulse mid-transmit -> txd=1 same cycle, counts 0, CTRL=DIV_RST.

Source files
------------

// File: rtl/uart_mmio_ctrl_if.sv
// uart_mmio_ctrl_if -- CPU data-bus bundle for the memory-mapped UART.
//
// Signals:
//   mem_addr_i  bus address (32 bit, full compare in the slave)
//   mem_data_i  bus write data (32 bit)
//   mem_oe_n    read strobe, active low
//   mem_we_n    write strobe, active low, wins over mem_oe_n
//   serial_o    read data returned by the slave, 0 when not addressed
//
// Modports:
//   master  the CPU / bus decoder side (drives address, data, strobes)
//   slave   the UART side (drives read data)
interface uart_mmio_ctrl_if;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic [31:0] serial_o;

  modport master (
    output mem_addr_i,
    output mem_data_i,
    output mem_oe_n,
    output mem_we_n,
    input  serial_o
  );

  modport slave (
    input  mem_addr_i,
    input  mem_data_i,
    input  mem_oe_n,
    input  mem_we_n,
    output serial_o
  );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl -- memory-mapped 8N1 UART with TX/RX FIFOs, runtime baud
// divisor and sticky error flags.
//
// Register map (offsets from BASE_ADDR):
//   +0x0 IER     interrupt enables (only with UART_IRQ_EN, else reads 0)
//   +0x4 CTRL    [15:0] clocks per bit, writes below 4 become 4
//   +0x8 DATA    write pushes TX byte, read returns RX head (popped after read)
//   +0xC STATUS  [0] TX not full [1] RX not empty [2] TX idle
//                [3] RX overrun [4] framing error [5] TX overflow (sticky)
//                [15:8] RX count [23:16] TX count
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   uart_mmio_ctrl_if.slave (address, write data, strobes, read data)
//   txd   serial output, idle high
//   rxd   serial input, asynchronous to clk
//   irq   registered level interrupt
//
// Configuration macro: UART_IRQ_EN enables the IER register and the irq
// output. Without it IER reads 0, writes are ignored and irq is tied low.
module uart_mmio_ctrl #(
  parameter int unsigned CLK_FREQ   = 109000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'hBFD003F0
) (
  input  logic             clk,
  input  logic             rst,
  uart_mmio_ctrl_if.slave  bus,
  output logic             txd,
  input  logic             rxd,
  output logic             irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD);
  localparam logic [31:0] ADDR_IER    = BASE_ADDR;
  localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_DATA   = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'hC;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------------
  // Bus front end: writes act on the we_n falling edge only; reads latch
  // the address on the oe_n falling edge and perform their side effects
  // on the first cycle oe_n is back high.
  // ---------------------------------------------------------------------
  logic        we_prev, oe_prev, rd_pending;
  logic [31:0] rd_addr;
  logic        wr_stb, rd_start, rd_done;
  logic        wr_data, wr_ctrl, rd_data_done, rd_status_done;

  assign wr_stb         = !bus.mem_we_n && we_prev;
  assign rd_start       = !bus.mem_oe_n && oe_prev && bus.mem_we_n;
  assign rd_done        = rd_pending && bus.mem_oe_n;
  assign wr_data        = wr_stb && (bus.mem_addr_i == ADDR_DATA);
  assign wr_ctrl        = wr_stb && (bus.mem_addr_i == ADDR_CTRL);
  assign rd_data_done   = rd_done && (rd_addr == ADDR_DATA);
  assign rd_status_done = rd_done && (rd_addr == ADDR_STATUS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_prev    <= 1'b1;
      oe_prev    <= 1'b1;
      rd_pending <= 1'b0;
      rd_addr    <= '0;
    end else begin
      we_prev <= bus.mem_we_n;
      oe_prev <= bus.mem_oe_n;
      if (rd_start) begin
        rd_pending <= 1'b1;
        rd_addr    <= bus.mem_addr_i;
      end else if (rd_done) begin
        rd_pending <= 1'b0;
      end
    end
  end

  // Baud divisor, clamped so every bit state lasts at least 4 clocks.
  logic [15:0] div;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= DIV_RST;
    end else if (wr_ctrl) begin
      div <= (bus.mem_data_i[15:0] < 16'd4) ? 16'd4 : bus.mem_data_i[15:0];
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO. A push into a full FIFO still succeeds when the serializer
  // pops in the same cycle.
  // ---------------------------------------------------------------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;
  logic [7:0]    tx_head;

  assign tx_full    = (tx_cnt == CW'(FIFO_DEPTH));
  assign tx_empty   = (tx_cnt == '0);
  assign tx_head    = tx_mem[tx_rp];
  assign tx_push    = wr_data && (!tx_full || tx_pop);
  assign tx_ovf_set = wr_data && tx_full && !tx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.mem_data_i[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // TX serializer. The next byte is fetched at the end of the stop bit so
  // consecutive frames run without an idle gap.
  // ---------------------------------------------------------------------
  tx_state_t   tx_state;
  logic [15:0] tx_tick, tx_div;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;
  logic        tx_end, tx_idle;

  assign tx_end  = (tx_tick == tx_div - 16'd1);
  assign tx_pop  = !tx_empty && ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_end));
  assign tx_idle = tx_empty && (tx_state == TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_div   <= DIV_RST;
      tx_shift <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (tx_pop) begin
            tx_shift <= tx_head;
            tx_div   <= div;
            tx_tick  <= '0;
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_end) begin
            tx_tick  <= '0;
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_tick <= tx_tick + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_end) begin
            tx_tick <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_tick <= tx_tick + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_end) begin
            tx_tick <= '0;
            if (tx_pop) begin
              tx_shift <= tx_head;
              tx_div   <= div;
              txd      <= 1'b0;
              tx_state <= TX_START;
            end else begin
              txd      <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_tick <= tx_tick + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX synchronizer plus one extra flop so a start bit is recognised only
  // on a genuine 1->0 transition (a low line after a framing error does
  // not restart reception).
  // ---------------------------------------------------------------------
  logic rx_sync1, rx_s, rx_prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1 <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= rxd;
      rx_s     <= rx_sync1;
      rx_prev  <= rx_s;
    end
  end

  // ---------------------------------------------------------------------
  // RX deserializer: start bit re-checked at half a bit, then data and
  // stop sampled once per bit period from that mid-bit point.
  // ---------------------------------------------------------------------
  rx_state_t   rx_state;
  logic [15:0] rx_tick, rx_div;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic        rx_end, rx_half_end, rx_stop_sample;

  assign rx_end         = (rx_tick == rx_div - 16'd1);
  assign rx_half_end    = (rx_tick == {1'b0, rx_div[15:1]} - 16'd1);
  assign rx_stop_sample = (rx_state == RX_STOP) && rx_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_div   <= DIV_RST;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_div   <= div;
            rx_tick  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_half_end) begin
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick <= rx_tick + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_end) begin
            rx_tick  <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_tick <= rx_tick + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_end) begin
            rx_tick  <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_tick <= rx_tick + 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO, filled by good frames and drained by DATA reads.
  // ---------------------------------------------------------------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_ovr_set, frm_set;
  logic          rx_frame_ok;

  assign rx_full     = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_empty    = (rx_cnt == '0);
  assign rx_frame_ok = rx_stop_sample && rx_s;
  assign frm_set     = rx_stop_sample && !rx_s;
  assign rx_pop      = rd_data_done && !rx_empty;
  assign rx_push     = rx_frame_ok && (!rx_full || rx_pop);
  assign rx_ovr_set  = rx_frame_ok && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CW'(1);
    end
  end

  // Sticky error flags: a new event in the clearing cycle keeps the flag.
  logic rx_ovr, frm_err, tx_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ovr  <= 1'b0;
      frm_err <= 1'b0;
      tx_ovf  <= 1'b0;
    end else begin
      if (rx_ovr_set)          rx_ovr  <= 1'b1;
      else if (rd_status_done) rx_ovr  <= 1'b0;
      if (frm_set)             frm_err <= 1'b1;
      else if (rd_status_done) frm_err <= 1'b0;
      if (tx_ovf_set)          tx_ovf  <= 1'b1;
      else if (rd_status_done) tx_ovf  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Optional interrupt logic.
  // ---------------------------------------------------------------------
  logic [31:0] ier_rd;
`ifdef UART_IRQ_EN
  logic [2:0] ier;
  logic       wr_ier;
  assign wr_ier = wr_stb && (bus.mem_addr_i == ADDR_IER);
  assign ier_rd = {29'd0, ier};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ier <= '0;
      irq <= 1'b0;
    end else begin
      if (wr_ier) ier <= bus.mem_data_i[2:0];
      irq <= |(ier & {(rx_ovr | frm_err | tx_ovf), tx_empty, !rx_empty});
    end
  end
`else
  assign ier_rd = 32'd0;
  assign irq    = 1'b0;
`endif

  // Read data is combinational and only driven while addressed for a read.
  logic [31:0] status;
  assign status = {8'd0, 8'(tx_cnt), 8'(rx_cnt), 2'b00, tx_ovf, frm_err, rx_ovr,
                   tx_idle, !rx_empty, !tx_full};

  always_comb begin
    bus.serial_o = 32'd0;
    if (!bus.mem_oe_n && bus.mem_we_n) begin
      case (bus.mem_addr_i)
        ADDR_IER:    bus.serial_o = ier_rd;
        ADDR_CTRL:   bus.serial_o = {16'd0, div};
        ADDR_DATA:   bus.serial_o = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp]};
        ADDR_STATUS: bus.serial_o = status;
        default:     bus.serial_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl -- self-checking bench for uart_mmio_ctrl.
// Drives the bus interface and rxd, captures txd, and compares against
// expectations computed from queues, counters and the 8N1 frame format.
module tb_uart_mmio_ctrl;
  localparam logic [31:0] A_IER   = 32'hBFD003F0;
  localparam logic [31:0] A_CTRL  = 32'hBFD003F4;
  localparam logic [31:0] A_DATA  = 32'hBFD003F8;
  localparam logic [31:0] A_STAT  = 32'hBFD003FC;
  localparam int          DEPTH   = 16;
  localparam int          DIV_RST = 109000000 / 9600;

  logic clk, rst, txd, rxd, irq;
  uart_mmio_ctrl_if bus();

  uart_mmio_ctrl #(
    .CLK_FREQ(109000000), .BAUD(9600), .FIFO_DEPTH(DEPTH), .BASE_ADDR(32'hBFD003F0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .txd(txd), .rxd(rxd), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic txd_samples [0:1023];
  logic [7:0] rx_model [$];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected STATUS word from the high-level state of the model.
  function automatic logic [31:0] exp_status(int rxc, int txc, bit idle, bit rxo, bit fe, bit txo);
    int v;
    v = (txc < DEPTH ? 1 : 0) + (rxc > 0 ? 2 : 0) + (idle ? 4 : 0) + (rxo ? 8 : 0)
      + (fe ? 16 : 0) + (txo ? 32 : 0) + rxc * 256 + txc * 65536;
    return 32'(v);
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input int hold);
    @(negedge clk);
    bus.mem_addr_i = a;
    bus.mem_data_i = d;
    bus.mem_we_n   = 1'b0;
    repeat (hold) @(negedge clk);
    bus.mem_we_n   = 1'b1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.mem_addr_i = a;
    bus.mem_oe_n   = 1'b0;
    @(negedge clk);
    d = bus.serial_o;
    bus.mem_oe_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (div) @(negedge clk);
    end
    rxd = stop;
    repeat (div) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic capture_txd(input int n, output bit found);
    found = 1'b0;
    for (int w = 0; w < 200 && !found; w++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    if (found) begin
      txd_samples[0] = txd;
      for (int k = 1; k < n; k++) begin
        @(negedge clk);
        txd_samples[k] = txd;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd: got %b, expected 1", txd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b, expected 0", irq); end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(0, 0, 1, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_status: got %h, expected %h", rd, exp_status(0, 0, 1, 0, 0, 0));
    end
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'(DIV_RST)) begin errors++; $display("[TB] FAIL reset_ctrl: got %0d, expected %0d", rd, DIV_RST); end
    bus_read(A_IER, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("[TB] FAIL reset_ier: got %h, expected 0", rd); end
    bus_read(A_DATA, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("[TB] FAIL empty_data_read: got %h, expected 0", rd); end
    bus_read(A_STAT + 32'h10, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("[TB] FAIL unmapped_read: got %h, expected 0", rd); end
  endtask

  // Runs nframes back-to-back with the given divisor and compares every
  // sample of every bit window against the frame format.
  task automatic run_tx_frames(input int div, input int nframes, input logic [7:0] b0,
                               input logic [7:0] b1, input string name);
    bit found;
    logic [7:0] bytes [2];
    logic [31:0] rd;
    bytes[0] = b0;
    bytes[1] = b1;
    bus_write(A_CTRL, 32'(div), 1);
    fork
      capture_txd(nframes * 10 * div, found);
      begin
        for (int f = 0; f < nframes; f++) bus_write(A_DATA, {24'd0, bytes[f]}, 1);
      end
    join
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL %s_start: got no start bit within 200 clk, expected one", name);
    end else begin
      for (int f = 0; f < nframes; f++) begin
        for (int k = 0; k < 10; k++) begin
          logic exp_b;
          logic got_b;
          bit bad;
          bad = 1'b0;
          exp_b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bytes[f][k-1];
          got_b = exp_b;
          for (int s = 0; s < div; s++) begin
            if (txd_samples[(f * 10 + k) * div + s] !== exp_b) begin
              bad = 1'b1;
              got_b = txd_samples[(f * 10 + k) * div + s];
            end
          end
          checks++;
          if (bad) begin
            errors++;
            $display("[TB] FAIL %s_frame%0d_bit%0d: got %b, expected %b", name, f, k, got_b, exp_b);
          end
        end
      end
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(0, 0, 1, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL %s_idle_status: got %h, expected %h", name, rd, exp_status(0, 0, 1, 0, 0, 0));
    end
  endtask

  task automatic test_tx_frame();
    run_tx_frames(16, 1, 8'h55, 8'h00, "tx55");
    run_tx_frames(16, 1, 8'($urandom_range(0, 255)), 8'h00, "txrand");
  endtask

  task automatic test_back_to_back();
    run_tx_frames($urandom_range(4, 12), 2, 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), "b2b");
  endtask

  task automatic test_we_hold();
    logic [31:0] rd;
    logic [15:0] dv;
    bus_write(A_CTRL, 32'd1000, 1);
    bus_write(A_DATA, 32'($urandom_range(0, 255)), 4);
    bus_write(A_DATA, 32'($urandom_range(0, 255)), 4);
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(0, 1, 0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL held_write_status: got %h, expected %h", rd, exp_status(0, 1, 0, 0, 0, 0));
    end
    bus_write(A_CTRL, 32'd2, 1);
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("[TB] FAIL ctrl_clamp: got %0d, expected 4", rd); end
    dv = 16'($urandom_range(4, 65535));
    bus_write(A_CTRL, {16'hFFFF, dv}, 1);
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== {16'd0, dv}) begin errors++; $display("[TB] FAIL ctrl_rw: got %h, expected %h", rd, {16'd0, dv}); end
    pulse_reset();
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rd;
    int accepted;
    accepted = 0;
    bus_write(A_CTRL, 32'd1000, 1);
    for (int i = 0; i < 18; i++) begin
      bus_write(A_DATA, 32'($urandom_range(0, 255)), 1);
      if (accepted < DEPTH + 1) accepted++;
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(0, accepted - 1, 0, 0, 0, 1)) begin
      errors++; $display("[TB] FAIL tx_ovf_status: got %h, expected %h", rd, exp_status(0, accepted - 1, 0, 0, 0, 1));
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(0, accepted - 1, 0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL tx_ovf_cleared: got %h, expected %h", rd, exp_status(0, accepted - 1, 0, 0, 0, 0));
    end
    checks++;
    if (txd !== 1'b0) begin errors++; $display("[TB] FAIL tx_start_bit_before_reset: got %b, expected 0", txd); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_tx_txd: got %b, expected 1", txd); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(0, 0, 1, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_mid_tx_status: got %h, expected %h", rd, exp_status(0, 0, 1, 0, 0, 0));
    end
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'(DIV_RST)) begin errors++; $display("[TB] FAIL reset_mid_tx_ctrl: got %0d, expected %0d", rd, DIV_RST); end
  endtask

  task automatic test_rx();
    logic [31:0] rd;
    logic [7:0] b;
    bus_write(A_CTRL, 32'd16, 1);
    send_rx(8'hA3, 16, 1'b1);
    rx_model.push_back(8'hA3);
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(rx_model.size(), 0, 1, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL rx_a3_status: got %h, expected %h", rd, exp_status(rx_model.size(), 0, 1, 0, 0, 0));
    end
    bus_read(A_DATA, rd);
    b = rx_model.pop_front();
    checks++;
    if (rd !== {24'd0, b}) begin errors++; $display("[TB] FAIL rx_a3_data: got %h, expected %h", rd, {24'd0, b}); end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(0, 0, 1, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL rx_after_pop_status: got %h, expected %h", rd, exp_status(0, 0, 1, 0, 0, 0));
    end
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      send_rx(b, 16, 1'b1);
      rx_model.push_back(b);
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(A_DATA, rd);
      b = rx_model.pop_front();
      checks++;
      if (rd !== {24'd0, b}) begin errors++; $display("[TB] FAIL rx_rand_data%0d: got %h, expected %h", i, rd, {24'd0, b}); end
    end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] rd;
    logic [7:0] b;
    bit ovr;
    ovr = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      send_rx(b, 16, 1'b1);
      if (rx_model.size() < DEPTH) rx_model.push_back(b);
      else ovr = 1'b1;
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(rx_model.size(), 0, 1, ovr, 0, 0)) begin
      errors++; $display("[TB] FAIL rx_ovr_status: got %h, expected %h", rd, exp_status(rx_model.size(), 0, 1, ovr, 0, 0));
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(rx_model.size(), 0, 1, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL rx_ovr_cleared: got %h, expected %h", rd, exp_status(rx_model.size(), 0, 1, 0, 0, 0));
    end
    while (rx_model.size() > 0) begin
      bus_read(A_DATA, rd);
      b = rx_model.pop_front();
      checks++;
      if (rd !== {24'd0, b}) begin errors++; $display("[TB] FAIL rx_drain: got %h, expected %h", rd, {24'd0, b}); end
    end
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (60) @(negedge clk);
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(0, 0, 1, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL rx_glitch_status: got %h, expected %h", rd, exp_status(0, 0, 1, 0, 0, 0));
    end
  endtask

  task automatic test_frame_error();
    logic [31:0] rd;
`ifdef UART_IRQ_EN
    bus_write(A_IER, 32'd4, 1);
    bus_read(A_IER, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("[TB] FAIL ier_rw: got %h, expected 4", rd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_before_err: got %b, expected 0", irq); end
`else
    bus_write(A_IER, 32'd7, 1);
    bus_read(A_IER, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("[TB] FAIL ier_disabled: got %h, expected 0", rd); end
`endif
    send_rx(8'($urandom_range(0, 255)), 16, 1'b0);
    repeat (20) @(negedge clk);
`ifdef UART_IRQ_EN
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_on_err: got %b, expected 1", irq); end
`else
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_tied_low: got %b, expected 0", irq); end
`endif
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(0, 0, 1, 0, 1, 0)) begin
      errors++; $display("[TB] FAIL frm_err_status: got %h, expected %h", rd, exp_status(0, 0, 1, 0, 1, 0));
    end
    bus_read(A_STAT, rd);
    checks++;
    if (rd !== exp_status(0, 0, 1, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL frm_err_cleared: got %h, expected %h", rd, exp_status(0, 0, 1, 0, 0, 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    bus.mem_addr_i = '0;
    bus.mem_data_i = '0;
    bus.mem_oe_n   = 1'b1;
    bus.mem_we_n   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_we_hold();
    test_tx_overflow();
    test_rx();
    test_rx_overflow();
    test_frame_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
